sqrt_arbiter: RTL

//  Round-robin scheduler sharing one 8-bit sqrt unit among NREQ requesters.
//  - Accepts one request at a time and drives the unit's enb_i/dt_i.
//  - Tracks busy_o through one computation and captures dt_o.
//  - Returns the result tagged with the requester id.

---
 rtl/sqrt_arbiter.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/sqrt_arbiter.sv
// sqrt_arbiter: round-robin front end that shares one 8-bit integer sqrt unit
// among NREQ clients. One request is in flight at a time. The result comes back
// tagged with the id of the client that asked for it.
// Optional build macro SQRT_ARB_TIMEOUT_EN adds a per-wait-state watchdog.
// The watchdog ends a stuck transaction with rsp_err_o=1 after TIMEOUT_CYC cycles.
module sqrt_arbiter #(
    parameter int NREQ        = 4,
    parameter int IDW         = $clog2(NREQ),
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NREQ-1:0]   req_i,
    input  logic [NREQ*8-1:0] req_data_i,
    output logic [NREQ-1:0]   gnt_o,
    output logic              sqrt_enb_o,
    output logic [7:0]        sqrt_dt_o,
    input  logic              sqrt_busy_i,
    input  logic [7:0]        sqrt_dt_i,
    output logic              rsp_valid_o,
    output logic [IDW-1:0]    rsp_id_o,
    output logic [7:0]        rsp_data_o,
    output logic              rsp_err_o,
    output logic              busy_o
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RESP      = 3'd4
    } state_t;

    // First requester at or after ptr, wrapping modulo NREQ.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                               input logic [IDW-1:0]  ptr);
        logic [IDW-1:0] pick;
        logic [IDW-1:0] sel;
        logic           found;
        int             idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            idx = (idx >= NREQ) ? (idx - NREQ) : idx;
            sel = idx[IDW-1:0];
            if (!found && req[sel]) begin
                found = 1'b1;
                pick  = sel;
            end
        end
        return pick;
    endfunction

    // Successor id modulo NREQ (NREQ need not be a power of two).
    function automatic logic [IDW-1:0] rr_next(input logic [IDW-1:0] id);
        return (id == IDW'(NREQ - 1)) ? '0 : (id + IDW'(1));
    endfunction

    state_t            state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [IDW-1:0]    id_q, id_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              enb_q, enb_d;
    logic [7:0]        dt_q, dt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]    rsp_id_q, rsp_id_d;
    logic [7:0]        rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic              busy_q, busy_d;
    logic [IDW-1:0]    win_s;
    logic [7:0]        win_data_s;
    logic              tmo_s;

`ifdef SQRT_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Watchdog: restarts on entry to each wait state, fires on its TIMEOUT_CYC-th waiting cycle.
    always_comb begin
        cnt_d = '0;
        tmo_s = 1'b0;
        case (state_q)
            ST_WAIT_BUSY: begin
                if (sqrt_busy_i) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    tmo_s = (cnt_q == CNT_LAST);
                end
            end
            ST_WAIT_DONE: begin
                if (sqrt_busy_i) begin
                    cnt_d = cnt_q + CW'(1);
                    tmo_s = (cnt_q == CNT_LAST);
                end else begin
                    cnt_d = '0;
                end
            end
            default: begin
                cnt_d = '0;
                tmo_s = 1'b0;
            end
        endcase
    end

    // Watchdog counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign tmo_s = 1'b0;
`endif

    // Round-robin winner and its operand for the current IDLE sample.
    always_comb begin
        win_s      = rr_pick(req_i, ptr_q);
        win_data_s = req_data_i[{win_s, 3'b000} +: 8];
    end

    // Next-state and next-output logic; all outputs are registered one cycle ahead.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        gnt_d       = '0;
        enb_d       = 1'b0;
        dt_d        = 8'h00;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req_i) begin
                    id_d    = win_s;
                    gnt_d   = NREQ'(1'b1) << win_s;
                    enb_d   = 1'b1;
                    dt_d    = win_data_s;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                ptr_d   = rr_next(id_q);
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (sqrt_busy_i) begin
                    state_d = ST_WAIT_DONE;
                end else if (tmo_s) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_data_d  = 8'h00;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    state_d = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_DONE: begin
                if (!sqrt_busy_i) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_data_d  = sqrt_dt_i;
                    state_d     = ST_RESP;
                end else if (tmo_s) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_data_d  = 8'h00;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, pointer and output registers; reset clears everything at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            gnt_q       <= '0;
            enb_q       <= 1'b0;
            dt_q        <= 8'h00;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= 8'h00;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            gnt_q       <= gnt_d;
            enb_q       <= enb_d;
            dt_q        <= dt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign sqrt_enb_o  = enb_q;
    assign sqrt_dt_o   = dt_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
    assign busy_o      = busy_q;

endmodule
